fp_divider: RTL

Sequential IEEE-754 single-precision divider computing resultDiv = A / B. It sits beside the combinational FP32 multiplier in the FPU datapath and shares its round-mode encoding and error/overflow flag semantics. It uses a radix-2 restoring mantissa divider with a start/done handshake and a fixed 27-cycle latency.

---
 rtl/fp_pkg.sv | 50 +++++
 rtl/fp_divider_if.sv | 25 ++
 rtl/fp_round_pack.sv | 58 +++++
 rtl/fp_divider.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// FP32 field widths, round-mode encodings and special-case codes shared by the FPU datapath blocks.
package fp_pkg;

  localparam int FP_W   = 32;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int BIAS   = 127;
  localparam int ITER   = 26;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam logic [1:0] RM_POS_INF = 2'b00;
  localparam logic [1:0] RM_NEG_INF = 2'b01;
  localparam logic [1:0] RM_RNE     = 2'b10;
  localparam logic [1:0] RM_ZERO    = 2'b11;

  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_NAN  = 2'd1,
    SP_INF  = 2'd2,
    SP_ZERO = 2'd3
  } special_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_ROUND = 2'd2
  } div_state_e;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W-1:0]     exp;
    logic [FRAC_W-1:0]    frac;
  } fp32_t;

  // Subnormals count as zero throughout the FPU.
  function automatic logic fp_is_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

  function automatic logic fp_is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp_divider_if.sv
// Operand/result bundle of the sequential FP32 divider: start/done handshake plus busy.
interface fp_divider_if;
  import fp_pkg::*;

  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  round_mode;
  logic        busy;
  logic        done;
  logic [31:0] resultDiv;
  logic        errorDiv;
  logic        overflowDiv;

  modport master (
    output start, A, B, round_mode,
    input  busy, done, resultDiv, errorDiv, overflowDiv
  );

  modport slave (
    input  start, A, B, round_mode,
    output busy, done, resultDiv, errorDiv, overflowDiv
  );

endinterface

// File: rtl/fp_round_pack.sv
// Rounds a normalized sign/exponent/mantissa with guard+sticky and packs it into FP32 with range flags.
// Purely combinational; no handshake.
module fp_round_pack
  import fp_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exponent,
  input  logic [23:0]       mant,
  input  logic              guard,
  input  logic              sticky,
  input  logic [1:0]        round_mode,
  output fp32_t             result,
  output logic              error,
  output logic              overflow
);

  logic              inc;
  logic [24:0]       mant_inc;
  logic [22:0]       frac_r;
  logic signed [9:0] exp_r;

  always_comb begin
    inc = 1'b0;
    case (round_mode)
      RM_RNE:     inc = guard & (sticky | mant[0]);
      RM_POS_INF: inc = ~sign & (guard | sticky);
      RM_NEG_INF: inc = sign & (guard | sticky);
      default:    inc = 1'b0;
    endcase
  end

  assign mant_inc = {1'b0, mant} + {24'd0, inc};

  always_comb begin
    // Carry out of the mantissa means it rolled over to 1.000..., renormalize.
    if (mant_inc[24]) begin
      frac_r = mant_inc[23:1];
      exp_r  = exponent + 10'sd1;
    end else begin
      frac_r = mant_inc[22:0];
      exp_r  = exponent;
    end
  end

  always_comb begin
    result   = '{sign: sign, exp: exp_r[7:0], frac: frac_r};
    error    = 1'b0;
    overflow = 1'b0;
    if (exp_r >= 10'sd255) begin
      result   = '{sign: sign, exp: 8'hFF, frac: 23'd0};
      error    = 1'b1;
      overflow = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      result = '{sign: sign, exp: 8'h00, frac: 23'd0};
    end
  end

endmodule

// File: rtl/fp_divider.sv
// Sequential FP32 divider A/B using a radix-2 restoring mantissa loop, one quotient bit per cycle.
// Fixed 27-cycle latency start->done; start is ignored while busy and accepted again in the done cycle.
module fp_divider
  import fp_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  fp_divider_if.slave   div
);

  div_state_e        state, state_d;
  logic [4:0]        cnt;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [23:0]       mb_q;
  logic [25:0]       rem_q;
  logic [25:0]       q_q;
  logic [1:0]        rm_q;
  special_e          sp_q;
  logic              sp_err_q;
  fp32_t             res_q;
  logic              err_q;
  logic              ovf_q;
  logic              done_q;

  // Operand classification at capture time.
  logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  special_e          sp_cap;
  logic              sp_err_cap;
  logic signed [9:0] exp_cap;

  assign a_zero = fp_is_zero(div.A);
  assign a_inf  = fp_is_inf(div.A);
  assign a_nan  = fp_is_nan(div.A);
  assign b_zero = fp_is_zero(div.B);
  assign b_inf  = fp_is_inf(div.B);
  assign b_nan  = fp_is_nan(div.B);

  always_comb begin
    sp_cap     = SP_NONE;
    sp_err_cap = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_cap     = SP_NAN;
      sp_err_cap = 1'b1;
    end else if (b_zero && !a_inf) begin
      sp_cap     = SP_INF;
      sp_err_cap = 1'b1;
    end else if (a_inf) begin
      sp_cap = SP_INF;
    end else if (a_zero || b_inf) begin
      sp_cap = SP_ZERO;
    end
  end

  assign exp_cap = $signed({2'b00, div.A[30:23]}) - $signed({2'b00, div.B[30:23]}) + 10'sd127;

  // One restoring step; the remainder stays below 2*Mb so 25 bits survive the shift.
  logic        rem_ge;
  logic [24:0] rem_sub;
  assign rem_ge  = rem_q >= {2'b00, mb_q};
  assign rem_sub = rem_ge ? 25'(rem_q - {2'b00, mb_q}) : rem_q[24:0];

  // Normalize the 26-bit quotient to a 24-bit mantissa plus guard/sticky.
  logic signed [9:0] norm_exp;
  logic [23:0]       norm_mant;
  logic              norm_g, norm_s;

  always_comb begin
    if (q_q[25]) begin
      norm_mant = q_q[25:2];
      norm_g    = q_q[1];
      norm_s    = q_q[0] | (rem_q != 26'd0);
      norm_exp  = exp_q;
    end else begin
      norm_mant = q_q[24:1];
      norm_g    = q_q[0];
      norm_s    = rem_q != 26'd0;
      norm_exp  = exp_q - 10'sd1;
    end
  end

  fp32_t pk_res;
  logic  pk_err, pk_ovf;

  fp_round_pack u_round_pack (
    .sign       (sign_q),
    .exponent   (norm_exp),
    .mant       (norm_mant),
    .guard      (norm_g),
    .sticky     (norm_s),
    .round_mode (rm_q),
    .result     (pk_res),
    .error      (pk_err),
    .overflow   (pk_ovf)
  );

  fp32_t fin_res;
  logic  fin_err, fin_ovf;

  always_comb begin
    fin_res = pk_res;
    fin_err = pk_err;
    fin_ovf = pk_ovf;
    case (sp_q)
      SP_NAN: begin
        fin_res = QNAN;
        fin_err = sp_err_q;
        fin_ovf = 1'b0;
      end
      SP_INF: begin
        fin_res = '{sign: sign_q, exp: 8'hFF, frac: 23'd0};
        fin_err = sp_err_q;
        fin_ovf = 1'b0;
      end
      SP_ZERO: begin
        fin_res = '{sign: sign_q, exp: 8'h00, frac: 23'd0};
        fin_err = 1'b0;
        fin_ovf = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (div.start) state_d = ST_DIV;
      ST_DIV:   if (cnt == 5'd0) state_d = ST_ROUND;
      ST_ROUND: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 5'd0;
      sign_q   <= 1'b0;
      exp_q    <= 10'sd0;
      mb_q     <= 24'd0;
      rem_q    <= 26'd0;
      q_q      <= 26'd0;
      rm_q     <= 2'b00;
      sp_q     <= SP_NONE;
      sp_err_q <= 1'b0;
      res_q    <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (div.start) begin
            cnt      <= 5'(ITER - 1);
            sign_q   <= div.A[31] ^ div.B[31];
            exp_q    <= exp_cap;
            mb_q     <= {1'b1, div.B[22:0]};
            rem_q    <= {3'b001, div.A[22:0]};
            q_q      <= 26'd0;
            rm_q     <= div.round_mode;
            sp_q     <= sp_cap;
            sp_err_q <= sp_err_cap;
          end
        end
        ST_DIV: begin
          rem_q <= {rem_sub, 1'b0};
          q_q   <= {q_q[24:0], rem_ge};
          cnt   <= cnt - 5'd1;
        end
        ST_ROUND: begin
          res_q  <= fin_res;
          err_q  <= fin_err;
          ovf_q  <= fin_ovf;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign div.busy        = state != ST_IDLE;
  assign div.done        = done_q;
  assign div.resultDiv   = res_q;
  assign div.errorDiv    = err_q;
  assign div.overflowDiv = ovf_q;

endmodule
